// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control sequencer.
// Holds the funct codes, the HiLo-write control code, the FSM state
// encoding and the decode helpers used by alu_ctrl_seq.
package alu_ctrl_pkg;

  // Supported funct codes
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;

  // Control code written on the HiLo cycle, and the idle code
  localparam logic [5:0] C_HILO = 6'b111111;
  localparam logic [5:0] C_NOP  = 6'b000000;

  // FSM state encoding
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HILO = 2'd2;

  // True for ops that go through the RUN/HILO sequence
  function automatic logic is_multicycle(input logic [5:0] funct,
                                         input logic       enable_div);
    return (funct == F_MULTU) || (enable_div && (funct == F_DIVU));
  endfunction

  // True for ops that complete in a single cycle
  function automatic logic is_single(input logic [5:0] funct);
    case (funct)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_iter_counter.sv
// Iteration counter for multi-cycle ops.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : force count to 0 (highest priority)
//   start      : load 1 (first RUN cycle of a new op)
//   inc        : count up by one
//   cnt        : current count
//   tc         : terminal count, high when cnt == ITER
module alu_iter_counter #(
  parameter int ITER  = 32,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             start,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CNT_W'(1);
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The controller clears on tc, so the count never passes ITER.
  assign tc = (cnt == CNT_W'(ITER));

endmodule

// File: rtl/alu_ctrl_seq.sv
// ALU control sequencer.
// Registers the funct code onto the four per-unit control buses and
// sequences MULTU/DIVU through ITER RUN cycles followed by one HILO cycle
// that presents the HiLo-write code.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   valid, funct        : funct code presented; sampled only in IDLE
//   ctrl_alu/sht/div/mux: registered control buses (always equal)
//   busy                : multi-cycle op in RUN or HILO
//   done, hilo_we       : one-cycle pulses coincident with HILO
//   illegal             : one-cycle pulse for an unsupported funct
//   iter_cnt            : current iteration count
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int ITER       = 32,
  parameter int CNT_W      = 7,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [5:0]       funct,
  output logic [5:0]       ctrl_alu,
  output logic [5:0]       ctrl_sht,
  output logic [5:0]       ctrl_div,
  output logic [5:0]       ctrl_mux,
  output logic             busy,
  output logic             done,
  output logic             hilo_we,
  output logic             illegal,
  output logic [CNT_W-1:0] iter_cnt
);

  logic [1:0] state;
  logic [5:0] ctrl_q;
  logic       cnt_clr;
  logic       cnt_start;
  logic       cnt_inc;
  logic       cnt_tc;
  logic       accept_mc;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    accept_mc = 1'b0;
    cnt_start = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    if (state == S_IDLE) begin
      accept_mc = valid && is_multicycle(funct, ENABLE_DIV);
      cnt_start = accept_mc;
    end else if (state == S_RUN) begin
      cnt_inc = !cnt_tc;
      cnt_clr = cnt_tc;
    end
  end

  alu_iter_counter #(
    .ITER  (ITER),
    .CNT_W (CNT_W)
  ) u_iter_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .start (cnt_start),
    .inc   (cnt_inc),
    .cnt   (iter_cnt),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ctrl_q  <= C_NOP;
      busy    <= 1'b0;
      done    <= 1'b0;
      hilo_we <= 1'b0;
      illegal <= 1'b0;
    end else begin
      // Pulses default low; only the cycle that raises them keeps them high.
      done    <= 1'b0;
      hilo_we <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid) begin
            if (accept_mc) begin
              ctrl_q <= funct;
              busy   <= 1'b1;
              state  <= S_RUN;
            end else if (is_single(funct)) begin
              ctrl_q <= funct;
            end else begin
              illegal <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (cnt_tc) begin
            ctrl_q  <= C_HILO;
            hilo_we <= 1'b1;
            done    <= 1'b1;
            state   <= S_HILO;
          end
        end
        S_HILO: begin
          // Drop the HiLo code after one cycle; valid is ignored here.
          ctrl_q <= C_NOP;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          ctrl_q <= C_NOP;
          busy   <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // One register fans out to all four units.
  assign ctrl_alu = ctrl_q;
  assign ctrl_sht = ctrl_q;
  assign ctrl_div = ctrl_q;
  assign ctrl_mux = ctrl_q;

endmodule
